// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the unified instruction/data SRAM arbiter.
// Holds the read-data owner encoding and the fixed word/byte-enable widths.
package sram_arb_pkg;

   localparam int WORD_W = 32;
   localparam int BE_W   = 4;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating refusal counter for the fetch port; hit flags that the count
// has reached max so the arbiter can hand the next contended cycle to fetch.
module arb_starve_cnt #(
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   input  logic [CNT_W-1:0] max,
   output logic             hit
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != max)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign hit = (r_cnt == max);

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch and data memory.
// Define SRAM_ARB_STARVE_GUARD_EN to build the fetch starvation guard.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dm_req,
   input  logic [ADDR_W-1:0] dm_addr,
   input  logic [BE_W-1:0]   dm_w_en,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic              dm_gnt,
   output logic              dm_rvalid,
   output logic [DATA_W-1:0] dm_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [BE_W-1:0]   mem_w_en,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall_req
);

   logic   w_force_if;
   owner_e r_owner;
   owner_e w_owner_nxt;

`ifdef SRAM_ARB_STARVE_GUARD_EN
   localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(STARVE_MAX);

   logic w_hit;

   arb_starve_cnt #(
      .CNT_W (CNT_W)
   ) u_starve_cnt (
      .clk (clk),
      .rst (rst),
      .inc (if_req & ~if_gnt),
      .clr (~if_req | if_gnt),
      .max (MAX_V),
      .hit (w_hit)
   );

   assign w_force_if = w_hit;
`else
   assign w_force_if = 1'b0;
`endif

   // hit is a registered compare, so feeding if_gnt back into the counter is loop-free
   assign if_gnt    = if_req & (~dm_req | w_force_if);
   assign dm_gnt    = dm_req & ~(if_req & w_force_if);
   assign stall_req = (if_req & ~if_gnt) | (dm_req & ~dm_gnt);

   always_comb begin
      mem_addr  = '0;
      mem_w_en  = '0;
      mem_wdata = '0;
      if (dm_gnt) begin
         mem_addr  = dm_addr;
         mem_w_en  = dm_w_en;
         mem_wdata = dm_wdata;
      end else if (if_gnt) begin
         mem_addr  = if_addr;
      end
   end

   always_comb begin
      w_owner_nxt = OWN_NONE;
      if (if_gnt) begin
         w_owner_nxt = OWN_IF;
      end else if (dm_gnt && (dm_w_en == '0)) begin
         w_owner_nxt = OWN_DM;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_owner <= OWN_NONE;
      end else begin
         r_owner <= w_owner_nxt;
      end
   end

   assign if_rvalid = (r_owner == OWN_IF);
   assign dm_rvalid = (r_owner == OWN_DM);
   assign if_rdata  = if_rvalid ? mem_rdata : '0;
   assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with a behavioural SRAM model.
module tb_sram_arbiter;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req;
   logic [ADDR_W-1:0] dm_addr;
   logic [3:0]        dm_w_en;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_gnt;
   logic              dm_rvalid;
   logic [DATA_W-1:0] dm_rdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_w_en;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_req;

   logic [31:0] sram [0:255];

   int n_cmp = 0;
   int n_err = 0;

   sram_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .dm_req    (dm_req),
      .dm_addr   (dm_addr),
      .dm_w_en   (dm_w_en),
      .dm_wdata  (dm_wdata),
      .dm_gnt    (dm_gnt),
      .dm_rvalid (dm_rvalid),
      .dm_rdata  (dm_rdata),
      .mem_addr  (mem_addr),
      .mem_w_en  (mem_w_en),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .stall_req (stall_req)
   );

   always #5 clk = ~clk;

   // Single-port SRAM: byte-masked write, one-cycle registered read
   always @(posedge clk) begin
      mem_rdata <= sram[mem_addr[9:2]];
      for (int b = 0; b < 4; b++) begin
         if (mem_w_en[b]) sram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp_v);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      if_req   = 1'b0;
      if_addr  = '0;
      dm_req   = 1'b0;
      dm_addr  = '0;
      dm_w_en  = '0;
      dm_wdata = '0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) sram[i] = 32'h0;
      sram[8'h04] = 32'h0000_0013;   // byte address 0x0010
      sram[8'h80] = 32'hFFFF_FFFF;   // byte address 0x0200
      mem_rdata = '0;
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
      chk("rst_dm_rdata", dm_rdata, 32'd0);
      chk("rst_stall", 32'(stall_req), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Lone fetch read
      tick();
      if_req = 1'b1; if_addr = 16'h0010;
      #1;
      chk("if_gnt", 32'(if_gnt), 32'd1);
      chk("if_stall", 32'(stall_req), 32'd0);
      chk("if_mem_addr", 32'(mem_addr), 32'h10);
      tick();
      idle();
      chk("if_rvalid", 32'(if_rvalid), 32'd1);
      chk("if_rdata", if_rdata, 32'h0000_0013);

      // Contended: dm full-word write wins
      if_req = 1'b1; if_addr = 16'h0010;
      dm_req = 1'b1; dm_addr = 16'h0100; dm_w_en = 4'hF; dm_wdata = 32'hDEAD_BEEF;
      #1;
      chk("wr_dm_gnt", 32'(dm_gnt), 32'd1);
      chk("wr_if_gnt", 32'(if_gnt), 32'd0);
      chk("wr_stall", 32'(stall_req), 32'd1);
      chk("wr_mem_w_en", 32'(mem_w_en), 32'hF);
      chk("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
      tick();
      idle();
      chk("wr_no_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("wr_no_dm_rvalid", 32'(dm_rvalid), 32'd0);

      // Read back the write
      dm_req = 1'b1; dm_addr = 16'h0100;
      tick();
      idle();
      chk("rd_dm_rvalid", 32'(dm_rvalid), 32'd1);
      chk("rd_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
      chk("rd_if_rdata", if_rdata, 32'd0);

      // Partial write over all-ones, then read back
      dm_req = 1'b1; dm_addr = 16'h0200; dm_w_en = 4'h3; dm_wdata = 32'h1234_5678;
      tick();
      dm_w_en = 4'h0; dm_wdata = '0;
      tick();
      idle();
      chk("pw_dm_rdata", dm_rdata, 32'hFFFF_5678);

      // Alternating dm then if
      dm_req = 1'b1; dm_addr = 16'h0100;
      tick();
      idle();
      if_req = 1'b1; if_addr = 16'h0010;
      #1;
      chk("alt_if_gnt", 32'(if_gnt), 32'd1);
      chk("alt_n1_dm_rvalid", 32'(dm_rvalid), 32'd1);
      chk("alt_n1_if_rvalid", 32'(if_rvalid), 32'd0);
      chk("alt_n1_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
      tick();
      idle();
      chk("alt_n2_if_rvalid", 32'(if_rvalid), 32'd1);
      chk("alt_n2_dm_rvalid", 32'(dm_rvalid), 32'd0);
      chk("alt_n2_if_rdata", if_rdata, 32'h0000_0013);
      tick();

      // Continuous contention
      if_req = 1'b1; if_addr = 16'h0010;
      dm_req = 1'b1; dm_addr = 16'h0100;
      for (int k = 0; k < 10; k++) begin
         logic exp_if;
`ifdef SRAM_ARB_STARVE_GUARD_EN
         exp_if = ((k % (STARVE_MAX + 1)) == STARVE_MAX);
`else
         exp_if = 1'b0;
`endif
         #1;
         chk($sformatf("starve_if_gnt_%0d", k), 32'(if_gnt), 32'(exp_if));
         chk($sformatf("starve_dm_gnt_%0d", k), 32'(dm_gnt), 32'(!exp_if));
         tick();
      end
      idle();
      tick();

      // Reset in the cycle after a dm read grant
      dm_req = 1'b1; dm_addr = 16'h0100;
      tick();
      chk("pre_rst_dm_rvalid", 32'(dm_rvalid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
      chk("mid_rst_dm_rdata", dm_rdata, 32'd0);
      tick();
      chk("rst_read_discarded", 32'(dm_rvalid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();
      tick();
      chk("post_rst_dm_rvalid", 32'(dm_rvalid), 32'd0);
      chk("post_rst_if_rvalid", 32'(if_rvalid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one single-port synchronous SRAM (32-bit word, byte write enables, 1-cycle read latency) between the instruction-fetch port and the data-memory port of the RV32I pipeline. This allows a unified instruction/data memory instead of separate IM and DM arrays. Grants are issued each cycle, and the block tracks which port owns the read data returning next cycle. It produces a stall request for the pipeline Controller whenever a requester is refused.

## Interface
Parameters:
- ADDR_W, 16, SRAM byte-address width
- DATA_W, 32, data width (fixed at 32; the write enable is 4 bits)
- STARVE_MAX, 4, consecutive refused fetch cycles before fetch is forced to win (starvation guard only)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- if_req  in  1  fetch read request
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  fetch read data valid
- if_rdata  out  32  fetch read data
- dm_req  in  1  data request, read or write
- dm_addr  in  ADDR_W  data address
- dm_w_en  in  4  byte write enables; 0 means read
- dm_wdata  in  32  store data
- dm_gnt  out  1  data granted this cycle
- dm_rvalid  out  1  data read data valid
- dm_rdata  out  32  data read data
- mem_addr  out  ADDR_W  SRAM address
- mem_w_en  out  4  SRAM byte write enables
- mem_wdata  out  32  SRAM write data
- mem_rdata  in  32  SRAM read data, one cycle after the address
- stall_req  out  1  a request was refused this cycle

## Operation
- **Grant logic:** combinational from the requests and the registered state.
  - Default priority: dm over if.
  - At most one grant per cycle.
- **SRAM drive:**
  - mem_addr, mem_w_en and mem_wdata come from the granted port.
  - With no grant: mem_w_en = 0 and mem_addr = 0.
  - Fetch grants always drive mem_w_en = 0.
- **Owner register:** records the port that owns the returning read data. Values are NONE, IF and DM.
  - Set to IF on an if_gnt.
  - Set to DM on a dm_gnt with dm_w_en == 0.
  - Set to NONE otherwise, including on writes.
- **Read return:**
  - if_rvalid = (owner == IF) and dm_rvalid = (owner == DM).
  - Each rdata output equals mem_rdata while its rvalid is high, and 0 otherwise.
- **Stall request:** stall_req = (if_req & ~if_gnt) | (dm_req & ~dm_gnt).
- **Requester rules:** a requester holds req, addr, w_en and wdata stable until it sees gnt. Dropping req before gnt is legal and abandons the request.
- **Starvation counter** (macro enabled):
  - Increments each cycle that if_req is high and if_gnt is low.
  - Saturates at STARVE_MAX.
  - When the count equals STARVE_MAX, fetch wins the next contended cycle, and the counter clears on that grant.
  - Clears whenever if_req is low.

## Timing
- Grant has zero-cycle latency and is issued in the same cycle as the request.
- Read data arrives 1 cycle after the grant, with a single-cycle rvalid pulse.
- A write completes at the clock edge that ends the grant cycle.
- Back-to-back grants to the same or alternating ports are allowed every cycle. The returning data always follows the owner registered in the previous cycle.
- **Reset (asynchronous assert, including mid-operation):**
  - owner = NONE; the counter is 0.
  - All rvalid and rdata outputs are 0 immediately.
  - Grants are still combinational, so the SRAM write data of an in-flight write is not guaranteed.
  - A read issued in the cycle reset asserts is discarded.
- **Simultaneous if_req and dm_req:** dm is granted and stall_req = 1, unless the starvation guard fires.

## Configuration
- SRAM_ARB_STARVE_GUARD_EN defined: the starvation counter and the forced fetch win are built as described above.
- Macro undefined: strict dm-over-if priority, no counter, and STARVE_MAX is ignored.

## Structure
- Shared package sram_arb_pkg holds:
  - the owner enum (OWN_NONE, OWN_IF, OWN_DM);
  - the word width of 32 and the byte-enable width of 4.
- Sub-module arb_starve_cnt: saturating counter with inputs inc, clr and max, and output hit. It is instantiated only under the macro.

## Test plan
- Reset, then if_req=1 with if_addr=0x0010 and SRAM word 0x00000013 at that address → if_gnt=1 in the same cycle; next cycle if_rvalid=1 and if_rdata=0x00000013; stall_req=0.
- if_req and dm_req both high, dm_w_en=0xF, dm_addr=0x0100, dm_wdata=0xDEADBEEF → dm_gnt=1, if_gnt=0, stall_req=1; the next cycle has no rvalid; a later dm read of 0x0100 returns 0xDEADBEEF.
- Write with dm_w_en=0x3 and wdata=0x12345678 over word 0xFFFFFFFF → a subsequent read returns 0xFFFF5678.
- Alternating grants: dm read in cycle n, if read in cycle n+1 → dm_rvalid in n+1 and if_rvalid in n+2, with no overlap.
- Starvation guard with the macro on and STARVE_MAX=4: both ports request continuously → dm is granted for 4 cycles, if is granted in the 5th, then the pattern repeats. With the macro off, if is never granted.
- rst asserted in the cycle after a dm read grant → dm_rvalid=0 and dm_rdata=0 immediately, and owner is NONE after release.
